// File: rtl/spi_cmd_decoder.sv
// SPI-slave (mode 0) front end: deserialises a 2-byte frame into a one-cycle
// fetch/load register-bus command and returns read data on MISO in the same frame.

module spi_cmd_decoder #(
  parameter int READ_LATCH_DELAY = 2
) (
  input  logic       i_rst_b,
  input  logic       i_sys_clk,
  input  logic       i_spi_sck,
  input  logic       i_spi_mosi,
  input  logic       i_spi_cs_b,
  output logic       o_spi_miso,
  output logic [4:0] o_ioc,
  output logic [7:0] o_data_out,
  output logic [3:0] o_cs_vec,
  output logic       o_fetch_cmd,
  output logic       o_load_cmd,
  input  logic [7:0] i_mod_data_0,
  input  logic [7:0] i_mod_data_1,
  input  logic [7:0] i_mod_data_2,
  input  logic [7:0] i_mod_data_3
);

  localparam int             WCW       = $clog2(READ_LATCH_DELAY + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(READ_LATCH_DELAY - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_FETCH, ST_WAIT, ST_DATA, ST_LOAD, ST_DONE
  } state_e;

  state_e         state_q,     state_d;
  logic [2:0]     sck_sync_q,  sck_sync_d;
  logic [1:0]     mosi_sync_q, mosi_sync_d;
  logic [2:0]     cs_sync_q,   cs_sync_d;
  logic [2:0]     bit_cnt_q,   bit_cnt_d;
  logic [WCW-1:0] wait_cnt_q,  wait_cnt_d;
  logic [6:0]     rx_q,        rx_d;
  logic [7:0]     tx_q,        tx_d;
  logic           rw_q,        rw_d;
  logic [1:0]     sel_q,       sel_d;
  logic [4:0]     ioc_q,       ioc_d;
  logic [3:0]     cs_vec_q,    cs_vec_d;
  logic [7:0]     data_out_q,  data_out_d;

  logic       sck_rise, sck_fall, cs_fall, cs_b_s, mosi_s;
  logic [7:0] rx_byte, mod_rdata;

  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], i_spi_sck};
    mosi_sync_d = {mosi_sync_q[0], i_spi_mosi};
    cs_sync_d   = {cs_sync_q[1:0], i_spi_cs_b};
  end

  // Sync flops reset low, so a CS already low at reset release never looks like a falling edge.
  assign cs_b_s   = cs_sync_q[1];
  assign cs_fall  = cs_sync_q[2] & ~cs_sync_q[1];
  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign mosi_s   = mosi_sync_q[1];
  assign rx_byte  = {rx_q, mosi_s};

  always_comb begin
    mod_rdata = 8'h00;
    case (sel_q)
      2'd0:    mod_rdata = i_mod_data_0;
      2'd1:    mod_rdata = i_mod_data_1;
      2'd2:    mod_rdata = i_mod_data_2;
      default: mod_rdata = 8'h00;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    rw_d       = rw_q;
    sel_d      = sel_q;
    ioc_d      = ioc_q;
    cs_vec_d   = cs_vec_q;
    data_out_d = data_out_q;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
          rx_d      = '0;
        end
      end
      ST_CMD, ST_FETCH, ST_WAIT, ST_DATA: begin
        if (cs_b_s) begin
          state_d  = ST_IDLE;
          cs_vec_d = '0;
        end else if (state_q == ST_CMD) begin
          if (sck_rise) begin
            rx_d      = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rw_d     = rx_byte[7];
              sel_d    = rx_byte[6:5];
              ioc_d    = rx_byte[4:0];
              cs_vec_d = 4'b0001 << rx_byte[6:5];
              state_d  = rx_byte[7] ? ST_DATA : ST_FETCH;
            end
          end
        end else if (state_q == ST_FETCH) begin
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end else if (state_q == ST_WAIT) begin
          if (wait_cnt_q == WAIT_LAST) begin
            tx_d    = mod_rdata;
            state_d = ST_DATA;
          end else begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
          end
        end else begin
          if (sck_rise) begin
            rx_d      = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rw_q) begin
                data_out_d = rx_byte;
                state_d    = ST_LOAD;
              end else begin
                state_d = ST_DONE;
              end
            end
          end else if (sck_fall && !rw_q && bit_cnt_q != 3'd0) begin
            // The last byte0 fall lands here with bit_cnt 0 and must not disturb bit7.
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
      end
      ST_LOAD: state_d = ST_DONE;
      ST_DONE: begin
        if (cs_b_s) begin
          state_d  = ST_IDLE;
          cs_vec_d = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cs_vec_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q     <= ST_IDLE;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      bit_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      sel_q       <= '0;
      ioc_q       <= '0;
      cs_vec_q    <= '0;
      data_out_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values regardless of order.
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      sel_q       <= sel_d;
      ioc_q       <= ioc_d;
      cs_vec_q    <= cs_vec_d;
      data_out_q  <= data_out_d;
    end
  end

  assign o_ioc       = ioc_q;
  assign o_data_out  = data_out_q;
  assign o_cs_vec    = cs_vec_q;
  assign o_fetch_cmd = (state_q == ST_FETCH);
  assign o_load_cmd  = (state_q == ST_LOAD);
  assign o_spi_miso  = (state_q == ST_DATA) & ~rw_q & ~cs_b_s & tx_q[7];

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: a mode-0 SPI master at sys_clk/8 drives directed and
// random frames; a frame-level model predicts strobes, held outputs and MISO bytes.

module tb_spi_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst_b, sck, mosi, cs_b;
  logic       miso, fetch, load;
  logic [4:0] ioc;
  logic [7:0] data_out;
  logic [3:0] cs_vec;
  logic [7:0] mod_data [4];

  int checks = 0, errors = 0;
  int cyc = 0;
  int fetch_cnt = 0, load_cnt = 0, both_cnt = 0, miso_bad = 0;
  int fetch_cyc = 0, load_cyc = 0, rise8_cyc = 0, rise16_cyc = 0;
  logic [3:0] fetch_cs, load_cs;
  logic [4:0] fetch_ioc, load_ioc;
  logic [7:0] load_data;
  logic       miso_zero;
  logic [4:0] last_ioc;
  logic [7:0] last_data;

  spi_cmd_decoder #(.READ_LATCH_DELAY(2)) dut (
    .i_rst_b      (rst_b),
    .i_sys_clk    (clk),
    .i_spi_sck    (sck),
    .i_spi_mosi   (mosi),
    .i_spi_cs_b   (cs_b),
    .o_spi_miso   (miso),
    .o_ioc        (ioc),
    .o_data_out   (data_out),
    .o_cs_vec     (cs_vec),
    .o_fetch_cmd  (fetch),
    .o_load_cmd   (load),
    .i_mod_data_0 (mod_data[0]),
    .i_mod_data_1 (mod_data[1]),
    .i_mod_data_2 (mod_data[2]),
    .i_mod_data_3 (mod_data[3])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling sys_clk edge.
  always @(negedge clk) begin
    if (fetch === 1'b1) begin
      fetch_cnt++;
      fetch_cyc = cyc;
      fetch_cs  = cs_vec;
      fetch_ioc = ioc;
    end
    if (load === 1'b1) begin
      load_cnt++;
      load_cyc  = cyc;
      load_cs   = cs_vec;
      load_ioc  = ioc;
      load_data = data_out;
    end
    if (fetch === 1'b1 && load === 1'b1) both_cnt++;
    if (miso_zero && miso !== 1'b0) miso_bad++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (time %0t)", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Mode-0 master: nbits taken MSB-first from data, sck half period = 4 sys_clk cycles.
  task automatic spi_frame(input logic [31:0] data, input int nbits, output logic [7:0] miso_b1);
    miso_b1 = 8'h00;
    @(negedge clk);
    cs_b = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = data[31-i];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      if (i == 7)  rise8_cyc  = cyc;
      if (i == 15) rise16_cyc = cyc;
      if (i >= 8 && i < 16) miso_b1 = {miso_b1[6:0], miso};
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    cs_b = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // Runs one frame and checks it against the frame-level rules.
  task automatic run_frame(input logic [31:0] data, input int nbits);
    logic [7:0] b0, b1, mb, exp_rd;
    logic       is_wr;
    logic [1:0] sel;
    int         f0, l0, m0;
    b0    = data[31:24];
    b1    = data[23:16];
    is_wr = b0[7];
    sel   = b0[6:5];
    exp_rd = (sel == 2'd3) ? 8'h00 : mod_data[sel];
    f0 = fetch_cnt;
    l0 = load_cnt;
    m0 = miso_bad;
    miso_zero = is_wr;
    spi_frame(data, nbits, mb);
    miso_zero = 1'b1;
    if (nbits >= 8) last_ioc = b0[4:0];
    if (is_wr && nbits >= 16) last_data = b1;

    check("fetch_count", fetch_cnt - f0, (!is_wr && nbits >= 8) ? 1 : 0);
    check("load_count",  load_cnt - l0,  (is_wr && nbits >= 16) ? 1 : 0);
    if (!is_wr && nbits >= 8) begin
      check("fetch_cs_vec",  32'(fetch_cs),  32'(1 << sel));
      check("fetch_ioc",     32'(fetch_ioc), 32'(b0[4:0]));
      check("fetch_latency", fetch_cyc - rise8_cyc, 3);
    end
    if (!is_wr && nbits >= 16) check("miso_byte", 32'(mb), 32'(exp_rd));
    if (is_wr && nbits >= 16) begin
      check("load_cs_vec",  32'(load_cs),   32'(1 << sel));
      check("load_ioc",     32'(load_ioc),  32'(b0[4:0]));
      check("load_data",    32'(load_data), 32'(b1));
      check("load_latency", load_cyc - rise16_cyc, 3);
    end
    check("cs_vec_idle",   32'(cs_vec),   0);
    check("ioc_hold",      32'(ioc),      32'(last_ioc));
    check("data_out_hold", 32'(data_out), 32'(last_data));
    check("miso_quiet",    miso_bad - m0, 0);
  endtask

  initial begin
    logic [7:0] rd_cmd;
    int f0, l0, nb, r;

    rst_b = 1'b0; cs_b = 1'b1; sck = 1'b0; mosi = 1'b0;
    miso_zero = 1'b1; last_ioc = '0; last_data = '0;
    for (int j = 0; j < 4; j++) mod_data[j] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ioc",      32'(ioc),      0);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_cs_vec",   32'(cs_vec),   0);
    check("rst_fetch",    32'(fetch),    0);
    check("rst_load",     32'(load),     0);
    check("rst_miso",     32'(miso),     0);
    rst_b = 1'b1;
    repeat (6) @(negedge clk);

    // Directed write, reads (sel 0 and the spare slot) and an aborted write.
    run_frame({8'hA5, 8'h3C, 16'h0000}, 16);
    mod_data[0] = 8'h01;
    run_frame({8'h02, 8'h00, 16'h0000}, 16);
    mod_data[3] = 8'hFF;
    run_frame({8'h63, 8'h00, 16'h0000}, 16);
    run_frame({8'hA5, 8'hF0, 16'h0000}, 12);
    mod_data[1] = 8'h96;
    run_frame({8'h29, 8'h00, 16'h0000}, 16);

    // Over-long write: only the first data byte is loaded.
    run_frame({8'hC7, 8'h55, 8'hAA, 8'h11}, 32);

    // Reset during WAIT of a read, then SCK activity with CS held low.
    mod_data[2] = 8'h3C;
    miso_zero = 1'b0;
    f0 = fetch_cnt;
    rd_cmd = 8'h4A;
    @(negedge clk);
    cs_b = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      mosi = rd_cmd[7-i];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      if (i < 7) begin
        repeat (4) @(negedge clk);
        sck = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    check("midrd_fetch",  fetch_cnt - f0, 1);
    check("midrd_cs_vec", 32'(cs_vec), 32'h4);
    rst_b = 1'b0;
    #1;
    check("midrst_ioc",      32'(ioc),      0);
    check("midrst_data_out", 32'(data_out), 0);
    check("midrst_cs_vec",   32'(cs_vec),   0);
    check("midrst_fetch",    32'(fetch),    0);
    check("midrst_load",     32'(load),     0);
    check("midrst_miso",     32'(miso),     0);
    miso_zero = 1'b1;
    last_ioc = '0;
    last_data = '0;
    sck = 1'b0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    f0 = fetch_cnt;
    l0 = load_cnt;
    for (int i = 0; i < 16; i++) begin
      mosi = 1'($urandom);
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    repeat (6) @(negedge clk);
    check("cslow_no_fetch", fetch_cnt - f0, 0);
    check("cslow_no_load",  load_cnt - l0,  0);
    check("cslow_cs_vec",   32'(cs_vec), 0);
    cs_b = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk);
    run_frame({8'h4A, 8'h00, 16'h0000}, 16);

    // Back-to-back reads of slot 2 with changing data.
    mod_data[2] = 8'h5A;
    run_frame({8'h44, 8'h00, 16'h0000}, 16);
    mod_data[2] = 8'hA5;
    run_frame({8'h44, 8'h00, 16'h0000}, 16);

    // Random frames, including aborts and over-long frames.
    for (int k = 0; k < 24; k++) begin
      for (int j = 0; j < 4; j++) mod_data[j] = 8'($urandom);
      r  = int'($urandom_range(0, 7));
      nb = (r < 5) ? 16 : (r == 5) ? 24 : int'($urandom_range(1, 15));
      run_frame($urandom, nb);
    end

    check("fetch_load_overlap", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
